// File: rtl/mis_stimulus_gen.sv
// Stimulus generator for a two-input MIS delay chain: programmable skew, lead order, hold and repeat count.
// Optional response checking of the chain output is enabled with `define MIS_RESP_CHECK_EN.
module mis_stimulus_gen #(
    parameter int SKEW_W = 8,
    parameter int HOLD_W = 8,
    parameter int REP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SKEW_W-1:0] skew,
    input  logic              lead_a2,
    input  logic [HOLD_W-1:0] hold,
    input  logic [REP_W-1:0]  num_reps,
`ifdef MIS_RESP_CHECK_EN
    input  logic              dut_out,
    output logic [REP_W-1:0]  err_count,
`endif
    output logic              stim_a1,
    output logic              stim_a2,
    output logic              busy,
    output logic              done,
    output logic [REP_W-1:0]  rep_count
);

    localparam int CNT_W = (SKEW_W > HOLD_W) ? SKEW_W : HOLD_W;

    typedef enum logic [2:0] {
        IDLE,
        RISE_SKEW,
        HIGH_HOLD,
        FALL_SKEW,
        LOW_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SKEW_W-1:0]  skew_l;
    logic [HOLD_W-1:0]  hold_l;
    logic [REP_W-1:0]   num_reps_l;
    logic               lead_a2_l;

    logic [SKEW_W-1:0]  skew_m1;
    logic               skew_last;
    logic               hold_last;
    logic               rep_more;

    // Skew phases are only entered with skew_l >= 1, so skew_m1 never wraps where it is used.
    assign skew_m1   = skew_l - 1'b1;
    assign skew_last = (cnt == CNT_W'(skew_m1));
    assign hold_last = (cnt == CNT_W'(hold_l));
    assign rep_more  = (rep_count < num_reps_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            skew_l     <= '0;
            hold_l     <= '0;
            num_reps_l <= '0;
            lead_a2_l  <= 1'b0;
            stim_a1    <= 1'b0;
            stim_a2    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rep_count  <= '0;
`ifdef MIS_RESP_CHECK_EN
            err_count  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                stim_a1 <= 1'b0;
                stim_a2 <= 1'b0;
                busy    <= 1'b0;
                cnt     <= '0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            skew_l     <= skew;
                            hold_l     <= hold;
                            num_reps_l <= num_reps;
                            lead_a2_l  <= lead_a2;
                            rep_count  <= '0;
                            cnt        <= '0;
`ifdef MIS_RESP_CHECK_EN
                            err_count  <= '0;
`endif
                            if (num_reps == '0) begin
                                done <= 1'b1;
                            end else begin
                                busy <= 1'b1;
                                if (skew == '0) begin
                                    stim_a1 <= 1'b1;
                                    stim_a2 <= 1'b1;
                                    state   <= HIGH_HOLD;
                                end else begin
                                    if (lead_a2) stim_a2 <= 1'b1;
                                    else         stim_a1 <= 1'b1;
                                    state <= RISE_SKEW;
                                end
                            end
                        end
                    end
                    RISE_SKEW: begin
                        if (skew_last) begin
                            stim_a1 <= 1'b1;
                            stim_a2 <= 1'b1;
                            cnt     <= '0;
                            state   <= HIGH_HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HIGH_HOLD: begin
                        if (hold_last) begin
`ifdef MIS_RESP_CHECK_EN
                            if (!dut_out && err_count != '1) err_count <= err_count + 1'b1;
`endif
                            cnt <= '0;
                            if (skew_l == '0) begin
                                stim_a1 <= 1'b0;
                                stim_a2 <= 1'b0;
                                if (rep_more) rep_count <= rep_count + 1'b1;
                                state <= LOW_HOLD;
                            end else begin
                                if (lead_a2_l) stim_a2 <= 1'b0;
                                else           stim_a1 <= 1'b0;
                                state <= FALL_SKEW;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    FALL_SKEW: begin
                        if (skew_last) begin
                            stim_a1 <= 1'b0;
                            stim_a2 <= 1'b0;
                            if (rep_more) rep_count <= rep_count + 1'b1;
                            cnt   <= '0;
                            state <= LOW_HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOW_HOLD: begin
                        if (hold_last) begin
`ifdef MIS_RESP_CHECK_EN
                            if (dut_out && err_count != '1) err_count <= err_count + 1'b1;
`endif
                            cnt <= '0;
                            if (rep_more) begin
                                if (skew_l == '0) begin
                                    stim_a1 <= 1'b1;
                                    stim_a2 <= 1'b1;
                                    state   <= HIGH_HOLD;
                                end else begin
                                    if (lead_a2_l) stim_a2 <= 1'b1;
                                    else           stim_a1 <= 1'b1;
                                    state <= RISE_SKEW;
                                end
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        stim_a1 <= 1'b0;
                        stim_a2 <= 1'b0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
